// File: rtl/vx_mem_arb_pkg.sv
// Shared helpers for the core-side memory port arbiter.
// Optional build macro VX_MEM_ARB_PERF_EN (see vx_mem_port_arb) adds stall counters.
package vx_mem_arb_pkg;

  localparam int SKID_DEPTH     = 2;
  localparam int PERF_CNT_WIDTH = 32;

  // Source-index field width; one bit even for a single channel so the tag layout is uniform.
  function automatic int sel_bits_f(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int tag_out_width_f(input int tag_in_width, input int num_reqs);
    return tag_in_width + sel_bits_f(num_reqs);
  endfunction

endpackage

// File: rtl/vx_mem_arb_skid.sv
// Two-entry elastic buffer with valid/ready on both sides; head entry drives the output.
// Handshake: a beat transfers on a side when valid && ready on the same rising edge.
module vx_mem_arb_skid
  import vx_mem_arb_pkg::*;
#(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready
);

  logic [DATAW-1:0] data0_q, data0_d;
  logic [DATAW-1:0] data1_q, data1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready  = (cnt_q != 2'(SKID_DEPTH));
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = data0_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    cnt_d   = cnt_q + 2'(push) - 2'(pop);
    if (push && pop) begin
      // Push while popping only happens with one entry held, so the new beat becomes the head.
      data0_d = in_data;
    end else if (pop) begin
      data0_d = data1_q;
    end else if (push) begin
      if (cnt_q == 2'd0) data0_d = in_data;
      else               data1_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data0_q <= '0;
      data1_q <= '0;
      cnt_q   <= '0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/vx_mem_port_arb.sv
// Round-robin merge of NUM_REQS L1 memory channels onto one core memory port with
// per-channel read tracking. Define VX_MEM_ARB_PERF_EN to add per-channel stall counters.
module vx_mem_port_arb
  import vx_mem_arb_pkg::*;
#(
  parameter int  NUM_REQS      = 3,
  parameter int  DATA_WIDTH    = 512,
  parameter int  ADDR_WIDTH    = 26,
  parameter int  TAG_IN_WIDTH  = 8,
  parameter int  MAX_PENDING   = 16,
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8,
  localparam int SEL_BITS      = sel_bits_f(NUM_REQS),
  localparam int TAG_OUT_WIDTH = tag_out_width_f(TAG_IN_WIDTH, NUM_REQS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              in_req_valid,
  input  logic [NUM_REQS-1:0]              in_req_rw,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0] in_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   in_req_data,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] in_req_tag,
  output logic [NUM_REQS-1:0]              in_req_ready,
  output logic [NUM_REQS-1:0]              in_rsp_valid,
  output logic [DATA_WIDTH-1:0]            in_rsp_data,
  output logic [TAG_IN_WIDTH-1:0]          in_rsp_tag,
  input  logic [NUM_REQS-1:0]              in_rsp_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0]          mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]         mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]         mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic                             busy
`ifdef VX_MEM_ARB_PERF_EN
  ,
  output logic [NUM_REQS*PERF_CNT_WIDTH-1:0] perf_stall
`endif
);

  localparam int CNT_WIDTH = $clog2(MAX_PENDING) + 1;

  typedef struct packed {
    logic                     rw;
    logic [BYTEEN_WIDTH-1:0]  byteen;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } mem_req_t;

  logic [SEL_BITS-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0] pend_cnt_q [NUM_REQS];
  logic [CNT_WIDTH-1:0] pend_cnt_d [NUM_REQS];
  logic [NUM_REQS-1:0]  eligible, pend_inc, pend_dec, pend_nz;
  logic                 grant_any, accept;
  logic [SEL_BITS-1:0]  grant_idx;
  logic                 skid_in_ready, skid_out_valid;
  mem_req_t             skid_in, skid_out;
  logic [SEL_BITS-1:0]  rsp_sel;
  logic                 rsp_sel_ok, rsp_fire, rsp_orphan;

  // A read-saturated channel is masked; writes never get a response so they bypass the limit.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i] = in_req_valid[i] &&
                    (in_req_rw[i] || (pend_cnt_q[i] != CNT_WIDTH'(MAX_PENDING)));
      pend_nz[i]  = (pend_cnt_q[i] != '0);
    end
  end

  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = SEL_BITS'(idx);
      end
    end
  end

  assign accept = grant_any && skid_in_ready && reset;

  always_comb begin
    in_req_ready = '0;
    if (accept) in_req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + SEL_BITS'(1);
  end

  always_comb begin
    int gi;
    gi             = int'(grant_idx);
    skid_in.rw     = in_req_rw[gi];
    skid_in.byteen = in_req_byteen[gi*BYTEEN_WIDTH +: BYTEEN_WIDTH];
    skid_in.addr   = in_req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    skid_in.data   = in_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    skid_in.tag    = {in_req_tag[gi*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx};
  end

  vx_mem_arb_skid #(
    .DATAW ($bits(mem_req_t))
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (grant_any && reset),
    .in_data   (skid_in),
    .in_ready  (skid_in_ready),
    .out_valid (skid_out_valid),
    .out_data  (skid_out),
    .out_ready (mem_req_ready)
  );

  assign mem_req_valid  = skid_out_valid;
  assign mem_req_rw     = skid_out.rw;
  assign mem_req_byteen = skid_out.byteen;
  assign mem_req_addr   = skid_out.addr;
  assign mem_req_data   = skid_out.data;
  assign mem_req_tag    = skid_out.tag;

  // Responses route on the index held in the low tag bits; an out-of-range index is sunk.
  assign rsp_sel     = mem_rsp_tag[SEL_BITS-1:0];
  assign rsp_sel_ok  = (int'(rsp_sel) < NUM_REQS);
  assign in_rsp_data = mem_rsp_data;
  assign in_rsp_tag  = mem_rsp_tag[TAG_OUT_WIDTH-1:SEL_BITS];
  assign rsp_fire    = mem_rsp_valid && mem_rsp_ready && rsp_sel_ok;

  always_comb begin
    in_rsp_valid  = '0;
    mem_rsp_ready = 1'b1;
    if (rsp_sel_ok) begin
      in_rsp_valid[rsp_sel] = mem_rsp_valid;
      mem_rsp_ready         = in_rsp_ready[rsp_sel];
    end
  end

  always_comb begin
    rsp_orphan = 1'b0;
    if (mem_rsp_valid && mem_rsp_ready) begin
      rsp_orphan = rsp_sel_ok ? (pend_cnt_q[rsp_sel] == '0) : 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      pend_inc[i]   = accept && !in_req_rw[i] && (grant_idx == SEL_BITS'(i));
      pend_dec[i]   = rsp_fire && (rsp_sel == SEL_BITS'(i)) && pend_nz[i];
      pend_cnt_d[i] = pend_cnt_q[i];
      if (pend_inc[i] && !pend_dec[i])      pend_cnt_d[i] = pend_cnt_q[i] + 1'b1;
      else if (pend_dec[i] && !pend_inc[i]) pend_cnt_d[i] = pend_cnt_q[i] - 1'b1;
    end
  end

  assign busy = skid_out_valid || (|pend_nz);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_REQS; i++) pend_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_REQS; i++) pend_cnt_q[i] <= pend_cnt_d[i];
    end
  end

  orphan_rsp_a: assert property (@(posedge clk) disable iff (!reset) !rsp_orphan);

`ifdef VX_MEM_ARB_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] stall_q [NUM_REQS];
  logic [PERF_CNT_WIDTH-1:0] stall_d [NUM_REQS];

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      stall_d[i] = stall_q[i] + PERF_CNT_WIDTH'(in_req_valid[i] && !in_req_ready[i]);
      perf_stall[i*PERF_CNT_WIDTH +: PERF_CNT_WIDTH] = stall_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQS; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) stall_q[i] <= stall_d[i];
    end
  end
`endif

endmodule
